// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and run-control unit for the F/D/E/W pipeline.
// Optional bubble/flush counter is built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int             XLEN         = 32,
  parameter int             AW           = 5,
  parameter int             OPW          = 6,
  parameter int             FWD_DEPTH    = 1,
  parameter int             JUMP_BUBBLES = 1,
  parameter logic [OPW-1:0] HALT_OP      = 6'b111111
) (
  input  logic            sysclk,
  input  logic            cpu_resetn,
  input  logic            d_jump,
  input  logic [AW-1:0]   e_rs,
  input  logic [AW-1:0]   e_rt,
  input  logic [XLEN-1:0] e_os_raw,
  input  logic [XLEN-1:0] e_ot_raw,
  input  logic            w_valid,
  input  logic [OPW-1:0]  w_op,
  input  logic [AW-1:0]   w_wreg,
  input  logic [XLEN-1:0] w_result,
  input  logic            w_redirect,
  output logic [XLEN-1:0] e_os,
  output logic [XLEN-1:0] e_ot,
  output logic            stall_f,
  output logic            bubble_fd,
  output logic            flush_de,
  output logic            halted,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retired_count,
  output logic [31:0]     bubble_count
);

  localparam logic [2:0] JB_LOAD = 3'(JUMP_BUBBLES);

  logic [FWD_DEPTH-1:0] hist_valid;
  logic [AW-1:0]        hist_reg  [FWD_DEPTH];
  logic [XLEN-1:0]      hist_data [FWD_DEPTH];
  logic [2:0]           jb;
  logic                 w_writes;

  assign w_writes = w_valid && (w_wreg != '0);

  // Oldest history entry is scanned first so newer matches overwrite it; W wins last.
  always_comb begin
    e_os = e_os_raw;
    e_ot = e_ot_raw;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (hist_valid[i] && (e_rs != '0) && (hist_reg[i] == e_rs)) e_os = hist_data[i];
      if (hist_valid[i] && (e_rt != '0) && (hist_reg[i] == e_rt)) e_ot = hist_data[i];
    end
    if (w_writes && (w_wreg == e_rs)) e_os = w_result;
    if (w_writes && (w_wreg == e_rt)) e_ot = w_result;
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      hist_valid <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) begin
        hist_reg[i]  <= '0;
        hist_data[i] <= '0;
      end
    end else if (!halted) begin
      for (int i = FWD_DEPTH - 1; i > 0; i--) begin
        hist_valid[i] <= hist_valid[i-1];
        hist_reg[i]   <= hist_reg[i-1];
        hist_data[i]  <= hist_data[i-1];
      end
      hist_valid[0] <= w_writes;
      hist_reg[0]   <= w_wreg;
      hist_data[0]  <= w_result;
    end
  end

  // A redirect cancels any pending jump shadow; a jump seen during a shadow is ignored.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      jb <= '0;
    end else if (w_redirect && !halted) begin
      jb <= '0;
    end else if (d_jump && (jb == '0) && !halted && (JB_LOAD != '0)) begin
      jb <= JB_LOAD;
    end else if (jb != '0) begin
      jb <= jb - 3'd1;
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      halted        <= 1'b0;
      cycle_count   <= '0;
      retired_count <= '0;
    end else if (!halted) begin
      cycle_count <= cycle_count + 32'd1;
      if (w_valid) retired_count <= retired_count + 32'd1;
      if (w_valid && (w_op == HALT_OP)) halted <= 1'b1;
    end
  end

  assign stall_f   = halted;
  assign flush_de  = halted | w_redirect;
  assign bubble_fd = (jb != '0) | w_redirect | halted;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] bubble_q;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      bubble_q <= '0;
    end else if (!halted && (bubble_fd || flush_de)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bubble_count = bubble_q;
`else
  assign bubble_count = '0;
`endif

endmodule
